// File: rtl/data_mem.sv
// data_mem: 32-bit word data memory with byte/half lane store merge and one-cycle registered reads.
// Build option DMEM_CLEAR_EN adds a post-reset sequencer that zeroes the array while holding mem_busy.
module data_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          mem_rw_mode,
    input  logic          mem_rd_en,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_write_data,
    input  logic [3:0]    mem_byte_en,
    output logic [DW-1:0] mem_read_data,
    output logic          mem_read_valid,
    output logic          mem_busy,
    output logic          mem_err
);
    // state | meaning
    // CLEAR | sweeping the array with zeros, one word per cycle; requests dropped
    // READY | normal load/store service, left only through reset
    typedef enum logic {CLEAR, READY} state_t;

    logic [DW-1:0] mem [DEPTH];
    state_t        state;
    logic          clear_we;
    logic [AW-1:0] clear_addr;

`ifdef DMEM_CLEAR_EN
    state_t        state_next;
    logic [AW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) cnt <= cnt + AW'(1);
        end
    end

    always_comb begin
        state_next = state;
        clear_we   = 1'b0;
        case (state)
            CLEAR: begin
                clear_we = 1'b1;
                if (cnt == AW'(DEPTH - 1)) state_next = READY;
            end
            default: state_next = READY;
        endcase
    end

    assign clear_addr = cnt;
`else
    assign state      = READY;
    assign clear_we   = 1'b0;
    assign clear_addr = '0;
`endif

    assign mem_busy = (state == CLEAR);

    logic          ready;
    logic          wr_go;
    logic          rd_go;
    logic [3:0]    lane_mask;
    logic [DW-1:0] lane_data;
    logic          be_illegal;

    assign ready = (state == READY);
    assign wr_go = ready & mem_rw_mode;
    assign rd_go = ready & mem_rd_en & ~mem_rw_mode;

    // Narrow stores are right-justified, so replicate them across every lane and let the mask pick.
    always_comb begin
        lane_mask  = 4'b0000;
        lane_data  = mem_write_data;
        be_illegal = 1'b0;
        case (mem_byte_en)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                lane_mask = mem_byte_en;
                lane_data = {4{mem_write_data[7:0]}};
            end
            4'b0011, 4'b1100: begin
                lane_mask = mem_byte_en;
                lane_data = {2{mem_write_data[15:0]}};
            end
            4'b1111: lane_mask = 4'b1111;
            4'b0000: lane_mask = 4'b0000;
            default: be_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else if (wr_go) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_mask[k]) mem[mem_addr][8*k +: 8] <= lane_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mem_read_data  <= '0;
            mem_read_valid <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            mem_read_valid <= rd_go;
            mem_err        <= wr_go & be_illegal;
            if (rd_go) mem_read_data <= mem[mem_addr];
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed literal checks plus randomized traffic against a word-array reference model.
// Works in both builds; the clear-sequence checks only run when DMEM_CLEAR_EN is defined.
module tb_data_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rw = 1'b0;
    logic        rd = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wd = '0;
    logic [3:0]  be = '0;
    logic [31:0] mem_read_data;
    logic        mem_read_valid;
    logic        mem_busy;
    logic        mem_err;

    data_mem dut (
        .i_clk         (clk),
        .i_rst         (rst_n),
        .mem_rw_mode   (rw),
        .mem_rd_en     (rd),
        .mem_addr      (addr),
        .mem_write_data(wd),
        .mem_byte_en   (be),
        .mem_read_data (mem_read_data),
        .mem_read_valid(mem_read_valid),
        .mem_busy      (mem_busy),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: plain word array, busy countdown, expected output registers
    logic [31:0] mdl [1024];
    bit          mknown [1024];
    int          busy_left = 0;
    logic [31:0] e_data = '0;
    bit          e_dknown = 1'b0;
    bit          e_valid = 1'b0;
    bit          e_err = 1'b0;
    int          sh;
    logic [31:0] m_msk;
    logic [31:0] m_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_data = '0;
            e_dknown = 1'b1;
            e_valid = 1'b0;
            e_err = 1'b0;
`ifdef DMEM_CLEAR_EN
            busy_left = 1024;
`else
            busy_left = 0;
`endif
        end else if (busy_left > 0) begin
            e_valid = 1'b0;
            e_err = 1'b0;
            mdl[1024 - busy_left] = '0;
            mknown[1024 - busy_left] = 1'b1;
            busy_left--;
        end else begin
            e_valid = 1'b0;
            e_err = 1'b0;
            if (rw) begin
                m_msk = '0;
                m_val = '0;
                if (be == 4'b0000) begin
                    m_msk = '0;
                end else if ($onehot(be)) begin
                    sh = 0;
                    for (int k = 0; k < 4; k++) if (be[k]) sh = 8 * k;
                    m_msk = 32'h0000_00FF << sh;
                    m_val = {24'b0, wd[7:0]} << sh;
                end else if (be == 4'b0011) begin
                    m_msk = 32'h0000_FFFF;
                    m_val = {16'b0, wd[15:0]};
                end else if (be == 4'b1100) begin
                    m_msk = 32'hFFFF_0000;
                    m_val = {wd[15:0], 16'b0};
                end else if (be == 4'b1111) begin
                    m_msk = 32'hFFFF_FFFF;
                    m_val = wd;
                end else begin
                    e_err = 1'b1;
                end
                if (m_msk != 0) begin
                    mdl[addr] = (mdl[addr] & ~m_msk) | m_val;
                    if (m_msk == 32'hFFFF_FFFF) mknown[addr] = 1'b1;
                end
            end else if (rd) begin
                e_valid = 1'b1;
                e_data = mdl[addr];
                e_dknown = mknown[addr];
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("valid", {31'b0, mem_read_valid}, {31'b0, e_valid});
            chk("err", {31'b0, mem_err}, {31'b0, e_err});
            chk("busy", {31'b0, mem_busy}, (busy_left > 0) ? 32'd1 : 32'd0);
            if (e_dknown) chk("read_data", mem_read_data, e_data);
        end
    end

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
        rw = 1'b1; rd = 1'b0; addr = a; wd = d; be = b;
        @(posedge clk); #1;
        rw = 1'b0;
    endtask

    task automatic rd_chk(input logic [9:0] a, input logic [31:0] exp, input string name);
        rd = 1'b1; rw = 1'b0; addr = a;
        @(posedge clk); #1;
        rd = 1'b0;
        chk({name, " valid"}, {31'b0, mem_read_valid}, 32'd1);
        chk(name, mem_read_data, exp);
    endtask

    logic [3:0] be_tab [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

    initial begin
        int n;
        #2 rst_n = 1'b0;
        #1;
        chk("reset data", mem_read_data, 32'h0);
        chk("reset valid", {31'b0, mem_read_valid}, 32'd0);
        chk("reset err", {31'b0, mem_err}, 32'd0);
        checking = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
        chk("busy after reset", {31'b0, mem_busy}, 32'd1);
        repeat (498) @(posedge clk);
        #1;
        rd = 1'b1; addr = 10'd3;
        @(posedge clk); #1;
        rd = 1'b0;
        chk("busy read dropped", {31'b0, mem_read_valid}, 32'd0);
        wr(10'd4, 32'h1234_5678, 4'b0101);
        chk("busy err dropped", {31'b0, mem_err}, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (mem_busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy cycles", n, 32'd1024);
        rd_chk(10'h3FF, 32'h0000_0000, "clear top word");
`else
        chk("busy tied low", {31'b0, mem_busy}, 32'd0);
`endif

        wr(10'd5, 32'hFFFF_FFFF, 4'b1111);
        wr(10'd5, 32'h0000_00AB, 4'b0100);
        rd_chk(10'd5, 32'hFFAB_FFFF, "byte lane 2");

        wr(10'd7, 32'h1122_3344, 4'b1111);
        wr(10'd7, 32'h0000_BEEF, 4'b1100);
        rd_chk(10'd7, 32'hBEEF_3344, "upper half");
        wr(10'd7, 32'h0000_CAFE, 4'b0011);
        rd_chk(10'd7, 32'hBEEF_CAFE, "lower half");

        wr(10'd9, 32'h0, 4'b1111);
        wr(10'd9, 32'h1234_5678, 4'b0101);
        chk("illegal be err", {31'b0, mem_err}, 32'd1);
        @(posedge clk); #1;
        chk("err one cycle", {31'b0, mem_err}, 32'd0);
        rd_chk(10'd9, 32'h0, "illegal be no write");

        rw = 1'b1; rd = 1'b1; addr = 10'd12; wd = 32'h0BAD_F00D; be = 4'b1111;
        @(posedge clk); #1;
        rw = 1'b0; rd = 1'b0;
        chk("conflict no valid", {31'b0, mem_read_valid}, 32'd0);
        rd_chk(10'd12, 32'h0BAD_F00D, "conflict write done");
        wr(10'd12, 32'hDEAD_BEEF, 4'b1111);
        rd_chk(10'd12, 32'hDEAD_BEEF, "read after write");
        @(posedge clk); #1;
        chk("read data holds", mem_read_data, 32'hDEAD_BEEF);

        for (int a = 0; a < 16; a++) wr(10'(a), 32'h0, 4'b1111);
        for (int i = 0; i < 3000; i++) begin
            rw = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 1) == 1);
            addr = ($urandom_range(0, 15) == 0) ? 10'($urandom) : 10'($urandom_range(0, 15));
            wd = $urandom;
            be = ($urandom_range(0, 8) == 8) ? 4'($urandom) : be_tab[$urandom_range(0, 7)];
            @(posedge clk); #1;
        end
        rw = 1'b0; rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Word-organised data memory that sits directly downstream of the store stage and the load path in execute.
- Consumes the store stage's write-mode flag, 10-bit word address, right-justified write data and byte enables.
- Relocates narrow store data into the correct byte lanes and serves full-word reads with one-cycle latency.
- Includes an optional post-reset clear sequencer that zeroes the array and holds the pipeline off while it runs.

Parameters:
DEPTH, 1024, number of 32-bit words; must equal 2**AW
AW, 10, word-address width
DW, 32, data width; fixed at 32 (4 byte lanes)

Ports:
i_clk  input  1  clock; all state changes on rising edge
i_rst  input  1  asynchronous active-low reset (0 = reset asserted)
mem_rw_mode  input  1  1 = write request this cycle, 0 = no write
mem_rd_en  input  1  read request from load path; ignored when mem_rw_mode=1
mem_addr  input  AW  word address
mem_write_data  input  DW  store data, right-justified (byte in [7:0], half in [15:0])
mem_byte_en  input  4  lane enables: one-hot (byte), 0011/1100 (half), 1111 (word)
mem_read_data  output  DW  registered full word read
mem_read_valid  output  1  one-cycle pulse qualifying mem_read_data
mem_busy  output  1  1 while clear sequencer runs; requests ignored
mem_err  output  1  one-cycle pulse on a write with illegal byte_en

Behaviour:
- Reset (i_rst=0, asynchronous): mem_read_data=0, mem_read_valid=0, mem_err=0, clear counter=0.
  - State = CLEAR when DMEM_CLEAR_EN is defined, else READY.
  - mem_busy = 1 in CLEAR, 0 in READY.
  - Array contents are not reset asynchronously.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes 0 to word[cnt] and increments cnt. When cnt==DEPTH-1, the write completes and the next state is READY. mem_busy=1 throughout (exactly DEPTH cycles after reset release).
  - READY: normal service; mem_busy=0. READY has no exit except reset.
  - Reset asserted mid-CLEAR restarts at cnt=0.
- Requests while mem_busy=1 are dropped: no write, no read_valid, no err.
- Write (READY, mem_rw_mode=1), committed at the clock edge:
  - byte_en 0001/0010/0100/1000 -> lane k[7:0] <= write_data[7:0]; lane k is byte 8k+7:8k.
  - byte_en 0011 -> word[15:0] <= write_data[15:0].
  - byte_en 1100 -> word[31:16] <= write_data[15:0].
  - byte_en 1111 -> word <= write_data.
  - byte_en 0000 -> no-op, no error.
  - Any other byte_en pattern -> no write; mem_err=1 for the next cycle.
  - Unenabled lanes always keep their old value.
- Read (READY, mem_rd_en=1, mem_rw_mode=0):
  - Cycle N+1: mem_read_data = word[mem_addr] as stored after edge N-1; mem_read_valid=1 for one cycle.
  - mem_read_data holds its value when no read occurs.
- Simultaneous mem_rw_mode=1 and mem_rd_en=1: the write is performed, the read is dropped, mem_read_valid=0.
- Read-after-write: a write at cycle N followed by a read of the same address at cycle N+1 returns the merged new word.
- Back-to-back reads: one result per cycle, in order, with no bubbles.
- mem_addr is AW bits wide, so all addresses are in range; there is no wrap logic.

Optional Feature:
DMEM_CLEAR_EN
- Defined: CLEAR state present; after reset release the array is zeroed over DEPTH cycles with mem_busy=1.
- Undefined: FSM resets directly to READY; mem_busy is tied to 0; the array powers up with undefined contents; the counter logic is removed.

Test Plan:
1. Clear sequence (DMEM_CLEAR_EN): release i_rst -> mem_busy=1 for exactly 1024 cycles, then 0; read addr 0x3FF -> mem_read_data=0x00000000, valid=1 one cycle later.
2. Byte lanes: write 0xFFFFFFFF, be=1111 to addr 5; then write data 0x000000AB with be=0100 -> read addr 5 returns 0xFFABFFFF.
3. Half lanes: on addr 7 write 0x11223344 be=1111; write 0x0000BEEF be=1100 -> read 0xBEEF3344; write 0x0000CAFE be=0011 -> read 0xBEEFCAFE.
4. Illegal enable: write 0x12345678 be=0101 to addr 9 (prior value 0) -> mem_err pulses 1 cycle; read addr 9 returns 0.
5. Conflict and hazard: same-cycle rw_mode=1 and rd_en=1 -> read_valid stays 0; write 0xDEADBEEF be=1111 at N then read same addr at N+1 -> 0xDEADBEEF at N+2.
6. Reset mid-clear: assert i_rst at clear cycle 500, release -> mem_busy=1 for a full 1024 cycles again; a request issued during busy produces no valid or err.
